// File: rtl/uart_msg_scheduler_if.sv
// Handshake bundle between the message scheduler, the character source,
// the UART receive path and the UART transmitter.
// Ports: msg_req, rx_valid/rx_data (receive), char_data/char_last/char_next
// (source), tx_busy/tx_start/tx_data (transmitter), busy/msg_done/echo_ovf.
// master: scheduler side; slave: surrounding environment.
interface uart_msg_scheduler_if;
   logic       msg_req;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic [7:0] char_data;
   logic       char_last;
   logic       char_next;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       busy;
   logic       msg_done;
   logic       echo_ovf;

   modport master (
      input  msg_req, rx_valid, rx_data,
      input  char_data, char_last, tx_busy,
      output char_next, tx_start, tx_data,
      output busy, msg_done, echo_ovf
   );

   modport slave (
      output msg_req, rx_valid, rx_data,
      output char_data, char_last, tx_busy,
      input  char_next, tx_start, tx_data,
      input  busy, msg_done, echo_ovf
   );
endinterface

// File: rtl/uart_msg_scheduler.sv
// Arbitrates one UART transmitter between byte echo and whole-message
// transmission from a character source, with settle and gap windows.
// Ports: clk, rst (sync, active high), bus (uart_msg_scheduler_if.master).
// Build option: MSG_CRLF_EN appends 0x0D 0x0A to every message.
module uart_msg_scheduler #(
   parameter int SETTLE_CYCLES = 2,
   parameter int GAP_CYCLES    = 0
) (
   input logic                  clk,
   input logic                  rst,
   uart_msg_scheduler_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, ECHO_START, MSG_SETTLE, MSG_START,
      WAIT_HI, WAIT_LO, GAP
   } state_t;

   // What the byte currently in flight is.
   typedef enum logic [1:0] {
      K_ECHO, K_MSG, K_CR, K_LF
   } kind_t;

   localparam logic [3:0] SETTLE_END = 4'(SETTLE_CYCLES - 1);
   // A zero gap still spends one cycle in GAP.
   localparam logic [7:0] GAP_END =
      (GAP_CYCLES > 1) ? 8'(GAP_CYCLES - 1) : 8'd0;

   state_t     state;
   kind_t      kind;
   logic       last;
   logic       msg_pend;
   logic       echo_pend;
   logic [7:0] echo_buf;
   logic [3:0] scnt;
   logic [7:0] gcnt;

   logic echo_free;
   logic pulse_cn;
   logic pulse_done;

   // The buffer counts as free in the cycle its byte is handed over.
   assign echo_free = !echo_pend ||
                      (state == ECHO_START && kind == K_ECHO);
   assign pulse_cn  = (kind == K_MSG);
`ifdef MSG_CRLF_EN
   assign pulse_done = (kind == K_LF);
`else
   assign pulse_done = (kind == K_MSG) && last;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         kind          <= K_ECHO;
         last          <= 1'b0;
         msg_pend      <= 1'b0;
         echo_pend     <= 1'b0;
         echo_buf      <= 8'd0;
         scnt          <= 4'd0;
         gcnt          <= 8'd0;
         bus.char_next <= 1'b0;
         bus.tx_start  <= 1'b0;
         bus.tx_data   <= 8'd0;
         bus.busy      <= 1'b0;
         bus.msg_done  <= 1'b0;
         bus.echo_ovf  <= 1'b0;
      end else begin
         bus.tx_start  <= 1'b0;
         bus.char_next <= 1'b0;
         bus.msg_done  <= 1'b0;

         if (bus.msg_req)
            msg_pend <= 1'b1;

         if (bus.rx_valid) begin
            if (echo_free) begin
               echo_buf  <= bus.rx_data;
               echo_pend <= 1'b1;
            end else begin
               bus.echo_ovf <= 1'b1;
            end
         end else if (state == ECHO_START && kind == K_ECHO) begin
            echo_pend <= 1'b0;
         end

         unique case (state)
            IDLE: begin
               if (echo_pend) begin
                  state        <= ECHO_START;
                  kind         <= K_ECHO;
                  bus.tx_start <= 1'b1;
                  bus.tx_data  <= echo_buf;
                  bus.busy     <= 1'b1;
               // A byte arriving now must be echoed before the message.
               end else if (!bus.rx_valid &&
                            (bus.msg_req || msg_pend)) begin
                  state    <= MSG_SETTLE;
                  kind     <= K_MSG;
                  msg_pend <= 1'b0;
                  scnt     <= 4'd0;
                  bus.busy <= 1'b1;
               end
            end
            ECHO_START: state <= WAIT_HI;
            MSG_SETTLE: begin
               if (scnt == SETTLE_END) begin
                  state        <= MSG_START;
                  bus.tx_start <= 1'b1;
                  bus.tx_data  <= bus.char_data;
                  last         <= bus.char_last;
               end else if (scnt != 4'hF) begin
                  scnt <= scnt + 4'd1;
               end
            end
            MSG_START: state <= WAIT_HI;
            WAIT_HI: begin
               if (bus.tx_busy)
                  state <= WAIT_LO;
            end
            WAIT_LO: begin
               if (!bus.tx_busy) begin
                  state <= GAP;
                  gcnt  <= 8'd0;
                  // Pulses are registered, so raise them on entry
                  // to the final GAP cycle.
                  if (GAP_END == 8'd0) begin
                     bus.char_next <= pulse_cn;
                     bus.msg_done  <= pulse_done;
                  end
               end
            end
            GAP: begin
               if (gcnt == GAP_END) begin
                  unique case (kind)
                     K_MSG: begin
                        if (!last) begin
                           state <= MSG_SETTLE;
                           scnt  <= 4'd0;
                        end else begin
`ifdef MSG_CRLF_EN
                           state        <= ECHO_START;
                           kind         <= K_CR;
                           bus.tx_start <= 1'b1;
                           bus.tx_data  <= 8'h0D;
`else
                           state    <= IDLE;
                           bus.busy <= 1'b0;
`endif
                        end
                     end
                     K_CR: begin
                        state        <= ECHO_START;
                        kind         <= K_LF;
                        bus.tx_start <= 1'b1;
                        bus.tx_data  <= 8'h0A;
                     end
                     default: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                     end
                  endcase
               end else begin
                  if (gcnt != 8'hFF)
                     gcnt <= gcnt + 8'd1;
                  if (gcnt + 8'd1 == GAP_END) begin
                     bus.char_next <= pulse_cn;
                     bus.msg_done  <= pulse_done;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Directed bench for uart_msg_scheduler with a 10-char source model
// ("2024311259") and a transmitter model busy for 5 cycles per byte.
module tb_uart_msg_scheduler;

`ifdef MSG_CRLF_EN
   localparam int MLEN = 12;
`else
   localparam int MLEN = 10;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   uart_msg_scheduler_if bus ();

   uart_msg_scheduler #(
      .SETTLE_CYCLES(2),
      .GAP_CYCLES   (0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] src_rom [10];
   logic [7:0] exp_b   [12];
   initial begin
      src_rom = '{8'h32, 8'h30, 8'h32, 8'h34, 8'h33,
                  8'h31, 8'h31, 8'h32, 8'h35, 8'h39};
      exp_b   = '{8'h32, 8'h30, 8'h32, 8'h34, 8'h33,
                  8'h31, 8'h31, 8'h32, 8'h35, 8'h39,
                  8'h0D, 8'h0A};
   end

   // Character source, reset by the same rst.
   int src_idx;
   always @(posedge clk)
      if (rst)
         src_idx <= 0;
      else if (bus.char_next)
         src_idx <= (src_idx == 9) ? 0 : src_idx + 1;
   assign bus.char_data = src_rom[src_idx];
   assign bus.char_last = (src_idx == 9);

   // Transmitter: busy for 5 cycles after each tx_start.
   int tx_cnt;
   always @(posedge clk)
      if (rst)
         tx_cnt <= 0;
      else if (bus.tx_start)
         tx_cnt <= 5;
      else if (tx_cnt != 0)
         tx_cnt <= tx_cnt - 1;
   assign bus.tx_busy = (tx_cnt != 0);

   // Output monitors.
   logic [7:0] txq [$];
   int         tx_cyc [$];
   int         cn_cnt = 0;
   int         cn_last = 0;
   int         done_cnt = 0;
   int         done_last = 0;
   always @(negedge clk) begin
      if (bus.tx_start) begin
         txq.push_back(bus.tx_data);
         tx_cyc.push_back(cyc);
      end
      if (bus.char_next) begin
         cn_cnt  <= cn_cnt + 1;
         cn_last <= cyc;
      end
      if (bus.msg_done) begin
         done_cnt  <= done_cnt + 1;
         done_last <= cyc;
      end
   end

   int vectors = 0;
   int errors  = 0;
   int n_mark  = 0;
   int base, cn0, dn0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic m, input logic r,
                        input logic [7:0] d);
      @(negedge clk);
      bus.msg_req  = m;
      bus.rx_valid = r;
      bus.rx_data  = d;
      n_mark       = cyc;
      @(negedge clk);
      bus.msg_req  = 1'b0;
      bus.rx_valid = 1'b0;
   endtask

   // Wait until at least n bytes started (bounded).
   task automatic wait_cnt(input int n, input string tag);
      int k = 0;
      while (txq.size() < n && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_tmo"}, 32'(k < 3000), 32'd1);
   endtask

   // Wait until n bytes started and the block went idle, then settle.
   task automatic wait_tx(input int n, input string tag);
      int k = 0;
      while (!(txq.size() >= n && !bus.busy) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_tmo"}, 32'(k < 3000), 32'd1);
      repeat (30) @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_tx_start"},  32'(bus.tx_start),  32'd0);
      chk({tag, "_tx_data"},   32'(bus.tx_data),   32'd0);
      chk({tag, "_char_next"}, 32'(bus.char_next), 32'd0);
      chk({tag, "_busy"},      32'(bus.busy),      32'd0);
      chk({tag, "_msg_done"},  32'(bus.msg_done),  32'd0);
      chk({tag, "_echo_ovf"},  32'(bus.echo_ovf),  32'd0);
   endtask

   initial begin
      bus.msg_req  = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'd0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Full message.
      base = txq.size(); cn0 = cn_cnt; dn0 = done_cnt;
      pulse(1'b1, 1'b0, 8'd0);
      wait_tx(base + MLEN, "msg1");
      chk("msg1_count", 32'(txq.size() - base), 32'(MLEN));
      for (int i = 0; i < MLEN; i++)
         chk($sformatf("msg1_byte%0d", i), 32'(txq[base + i]),
             32'(exp_b[i]));
      chk("msg1_first_lat", 32'(tx_cyc[base] - n_mark), 32'd3);
      chk("msg1_char_next", 32'(cn_cnt - cn0), 32'd10);
      chk("msg1_done", 32'(done_cnt - dn0), 32'd1);
      chk("msg1_busy", 32'(bus.busy), 32'd0);
`ifndef MSG_CRLF_EN
      chk("msg1_done_with_cn", 32'(done_last), 32'(cn_last));
`endif

      // Echo from IDLE.
      base = txq.size(); cn0 = cn_cnt;
      pulse(1'b0, 1'b1, 8'h41);
      wait_tx(base + 1, "echo");
      chk("echo_count", 32'(txq.size() - base), 32'd1);
      chk("echo_byte", 32'(txq[base]), 32'h41);
      chk("echo_lat", 32'(tx_cyc[base] - n_mark), 32'd2);
      chk("echo_no_cn", 32'(cn_cnt - cn0), 32'd0);
      chk("echo_no_ovf", 32'(bus.echo_ovf), 32'd0);

      // Echo during a message, second byte overflows.
      base = txq.size(); dn0 = done_cnt;
      pulse(1'b1, 1'b0, 8'd0);
      wait_cnt(base + 3, "ovf_c3");
      pulse(1'b0, 1'b1, 8'h41);
      pulse(1'b0, 1'b1, 8'h42);
      chk("ovf_flag", 32'(bus.echo_ovf), 32'd1);
      wait_tx(base + MLEN + 1, "ovf");
      chk("ovf_count", 32'(txq.size() - base), 32'(MLEN + 1));
      chk("ovf_echo_after", 32'(txq[base + MLEN]), 32'h41);
      chk("ovf_done", 32'(done_cnt - dn0), 32'd1);
      chk("ovf_done_first", 32'(done_last < tx_cyc[base + MLEN]),
          32'd1);
      chk("ovf_sticky", 32'(bus.echo_ovf), 32'd1);

      // Echo and message requested together: echo first.
      base = txq.size();
      pulse(1'b1, 1'b1, 8'h55);
      wait_tx(base + MLEN + 1, "both");
      chk("both_count", 32'(txq.size() - base), 32'(MLEN + 1));
      chk("both_echo", 32'(txq[base]), 32'h55);
      chk("both_msg0", 32'(txq[base + 1]), 32'h32);

      // Three requests during a message: one repeat.
      base = txq.size(); cn0 = cn_cnt; dn0 = done_cnt;
      pulse(1'b1, 1'b0, 8'd0);
      wait_cnt(base + 2, "rep_a");
      pulse(1'b1, 1'b0, 8'd0);
      wait_cnt(base + 4, "rep_b");
      pulse(1'b1, 1'b0, 8'd0);
      wait_cnt(base + 6, "rep_c");
      pulse(1'b1, 1'b0, 8'd0);
      wait_tx(base + 2 * MLEN, "rep");
      chk("rep_count", 32'(txq.size() - base), 32'(2 * MLEN));
      chk("rep_second0", 32'(txq[base + MLEN]), 32'h32);
      chk("rep_done", 32'(done_cnt - dn0), 32'd2);
      chk("rep_cn", 32'(cn_cnt - cn0), 32'd20);

      // Reset in WAIT_LO of character 5.
      base = txq.size(); cn0 = cn_cnt; dn0 = done_cnt;
      pulse(1'b1, 1'b0, 8'd0);
      wait_cnt(base + 5, "rst_c5");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("rst_mid");
      rst = 1'b0;
      chk("rst_cn", 32'(cn_cnt - cn0), 32'd4);
      chk("rst_done", 32'(done_cnt - dn0), 32'd0);
      repeat (20) @(negedge clk);
      chk("rst_quiet", 32'(txq.size() - base), 32'd5);
      base = txq.size();
      pulse(1'b1, 1'b0, 8'd0);
      wait_tx(base + MLEN, "restart");
      chk("restart_count", 32'(txq.size() - base), 32'(MLEN));
      chk("restart_first", 32'(txq[base]), 32'h32);
      chk("restart_last", 32'(txq[base + MLEN - 1]),
          32'(exp_b[MLEN - 1]));

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
